tcam_rule_loader: RTL and testbench

- Write-side engine for the 32-rule × 28-bit TCAM: accepts ternary rule install, delete and clear requests, and rewrites the SRAM-backed virtual TCAM blocks.
- Keeps a shadow rule table (value, care-mask, valid per rule) and regenerates every affected SRAM word from it, because the TCAM port returns only the priority-encoded match index, not raw words.
- Sits between the control/CSR path and the TCAM write port; the top level muxes the TCAM inputs to this block while `busy_o` is high.

---
 rtl/tcam_pkg.sv | 44 ++++
 rtl/tcam_rule_loader_if.sv | 32 +++
 rtl/tcam_word_gen.sv | 26 ++
 rtl/tcam_rule_loader.sv | 138 +++++++++++++
 tb/tb_tcam_rule_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcam_pkg.sv
// Shared constants, types and slice helpers for the TCAM rule loader.
// The TCAM is 32 rules x 28-bit keys, split into 4 slices of 7 bits.
package tcam_pkg;

  localparam int NUM_RULES  = 32;
  localparam int KEY_W      = 28;
  localparam int SLICE_W    = 7;
  localparam int NUM_SLICES = 4;
  localparam int NUM_WORDS  = 512;

  localparam logic [8:0] LAST_WORD = 9'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    INSTALL = 2'b00,
    DELETE  = 2'b01,
    CLEAR   = 2'b10,
    NOP     = 2'b11
  } tcam_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } loader_state_e;

  typedef struct packed {
    logic [KEY_W-1:0] value;
    logic [KEY_W-1:0] care;
    logic             valid;
  } tcam_rule_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Slice 0 is the most significant 7 bits of the key.
  function automatic logic [SLICE_W-1:0] key_slice(
    input logic [KEY_W-1:0]              key,
    input logic [$clog2(NUM_SLICES)-1:0] s
  );
    return key[KEY_W - SLICE_W * (int'(s) + 1) +: SLICE_W];
  endfunction

endpackage

// File: rtl/tcam_rule_loader_if.sv
// Request and TCAM write-port bundle for the rule loader.
// The slave modport is the loader; the master is the control path / TCAM side.
interface tcam_rule_loader_if;
  import tcam_pkg::*;

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [1:0]           req_op_i;
  logic [4:0]           req_idx_i;
  logic [KEY_W-1:0]     req_value_i;
  logic [KEY_W-1:0]     req_care_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 tcam_csb_o;
  logic                 tcam_web_o;
  logic [3:0]           tcam_wmask_o;
  logic [27:0]          tcam_addr_o;
  logic [NUM_RULES-1:0] tcam_wdata_o;

  modport master (
    output req_valid_i, req_op_i, req_idx_i, req_value_i, req_care_i,
    input  req_ready_o, busy_o, done_o,
    input  tcam_csb_o, tcam_web_o, tcam_wmask_o, tcam_addr_o, tcam_wdata_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_idx_i, req_value_i, req_care_i,
    output req_ready_o, busy_o, done_o,
    output tcam_csb_o, tcam_web_o, tcam_wmask_o, tcam_addr_o, tcam_wdata_o
  );

endinterface

// File: rtl/tcam_word_gen.sv
// Builds one 32-bit SRAM word from the shadow rule table: bit r is set when
// rule r is valid and its cared-for slice bits equal the slice address.
module tcam_word_gen
  import tcam_pkg::*;
(
  input  tcam_rule_t           i_rules [NUM_RULES],
  input  logic [8:0]           i_cnt,
  output logic [NUM_RULES-1:0] o_word
);

  logic [1:0]         w_slice;
  logic [SLICE_W-1:0] w_addr;

  assign w_slice = i_cnt[8:7];
  assign w_addr  = i_cnt[SLICE_W-1:0];

  for (genvar r = 0; r < NUM_RULES; r++) begin : g_cmp
    logic [SLICE_W-1:0] w_val;
    logic [SLICE_W-1:0] w_care;

    assign w_val     = key_slice(i_rules[r].value, w_slice);
    assign w_care    = key_slice(i_rules[r].care, w_slice);
    assign o_word[r] = i_rules[r].valid & ~|((w_addr ^ w_val) & w_care);
  end

endmodule

// File: rtl/tcam_rule_loader.sv
// Write-side engine for the SRAM-backed TCAM: updates the shadow rule table on
// a request, then rewrites all 512 words of the affected byte lane(s).
//
// state | meaning
// IDLE  | ready for a request
// WRITE | one TCAM word written per cycle, 512 cycles
// DONE  | one-cycle completion pulse
module tcam_rule_loader #(
  parameter int NUM_RULES = 32,
  parameter int KEY_W     = 28
) (
  input logic               clk_i,
  input logic               rst_ni,
  tcam_rule_loader_if.slave bus
);
  import tcam_pkg::*;

  loader_state_e        r_state;
  loader_state_e        w_state_nxt;
  logic [8:0]           r_cnt;
  logic [8:0]           w_cnt_nxt;
  logic [3:0]           r_lane;
  logic [3:0]           w_lane_nxt;
  tcam_rule_t           r_rules     [NUM_RULES];
  tcam_rule_t           w_rules_nxt [NUM_RULES];
  tcam_op_e             w_op;
  logic                 w_accept;
  logic [NUM_RULES-1:0] w_word;

  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_csb;
  logic                 r_web;
  logic [3:0]           r_wmask;
  logic [27:0]          r_addr;
  logic [NUM_RULES-1:0] r_wdata;

  assign w_op     = tcam_op_e'(bus.req_op_i);
  assign w_accept = r_ready & bus.req_valid_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lane_nxt  = r_lane;
    w_rules_nxt = r_rules;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (w_op == NOP) ? DONE : WRITE;
          w_lane_nxt  = (w_op == CLEAR) ? 4'hF : lane_mask(bus.req_idx_i[4:3]);
          case (w_op)
            INSTALL: begin
              w_rules_nxt[bus.req_idx_i].value = bus.req_value_i[KEY_W-1:0];
              w_rules_nxt[bus.req_idx_i].care  = bus.req_care_i[KEY_W-1:0];
              w_rules_nxt[bus.req_idx_i].valid = 1'b1;
            end
            DELETE: w_rules_nxt[bus.req_idx_i].valid = 1'b0;
            CLEAR: begin
              for (int r = 0; r < NUM_RULES; r++) begin
                w_rules_nxt[r].valid = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (r_cnt == LAST_WORD) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fed with next-cycle table and counter so the registered word lines up
  // with the first write cycle right after acceptance.
  tcam_word_gen u_word_gen (
    .i_rules (w_rules_nxt),
    .i_cnt   (w_cnt_nxt),
    .o_word  (w_word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lane  <= '0;
      for (int r = 0; r < NUM_RULES; r++) begin
        r_rules[r].valid <= 1'b0;
      end
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lane  <= w_lane_nxt;
      r_rules <= w_rules_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      if (w_state_nxt == WRITE) begin
        r_csb   <= 1'b0;
        r_web   <= 1'b0;
        r_wmask <= w_lane_nxt;
        r_addr  <= {19'd0, w_cnt_nxt};
        r_wdata <= w_word;
      end else begin
        r_csb   <= 1'b1;
        r_web   <= 1'b1;
        r_wmask <= '0;
        r_addr  <= '0;
        r_wdata <= '0;
      end
    end
  end

  assign bus.req_ready_o  = r_ready;
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.tcam_csb_o   = r_csb;
  assign bus.tcam_web_o   = r_web;
  assign bus.tcam_wmask_o = r_wmask;
  assign bus.tcam_addr_o  = r_addr;
  assign bus.tcam_wdata_o = r_wdata;

endmodule

// File: tb/tb_tcam_rule_loader.sv
// Self-checking bench for tcam_rule_loader: a rule-level model predicts every
// written word, and an SRAM image built from the write port answers searches.
module tb_tcam_rule_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  tcam_rule_loader_if bus ();

  tcam_rule_loader #(.NUM_RULES(32), .KEY_W(28)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // rule-level model and emulated SRAM contents
  logic [27:0] m_val  [32];
  logic [27:0] m_care [32];
  logic [31:0] m_valid = '0;
  logic [31:0] sram [512];
  logic [31:0] cap  [512];

  function automatic void model_apply(input logic [1:0] op, input logic [4:0] idx,
                                      input logic [27:0] val, input logic [27:0] care);
    case (op)
      2'b00: begin m_val[idx] = val; m_care[idx] = care; m_valid[idx] = 1'b1; end
      2'b01: m_valid[idx] = 1'b0;
      2'b10: m_valid = '0;
      default: ;
    endcase
  endfunction

  // Word c holds, for each rule, whether slice (c/128) of a key equal to c%128
  // would satisfy that rule's cared-for bits within the slice.
  function automatic logic [31:0] model_word(input int c);
    logic [31:0] w = '0;
    int          s = c / 128;
    logic [27:0] probe = 28'(c % 128) << ((3 - s) * 7);
    logic [27:0] field = 28'h7F << ((3 - s) * 7);
    for (int r = 0; r < 32; r++)
      w[r] = m_valid[r] && (((probe ^ m_val[r]) & m_care[r] & field) == 28'h0);
    return w;
  endfunction

  function automatic logic [31:0] model_match(input logic [27:0] key);
    logic [31:0] w = '0;
    for (int r = 0; r < 32; r++)
      w[r] = m_valid[r] && (((key ^ m_val[r]) & m_care[r]) == 28'h0);
    return w;
  endfunction

  function automatic logic [31:0] sram_search(input logic [27:0] key);
    logic [31:0] w = '1;
    for (int s = 0; s < 4; s++)
      w &= sram[s * 128 + int'((key >> ((3 - s) * 7)) & 28'h7F)];
    return w;
  endfunction

  // Issue one request, check every cycle up to ready returning. With hold set,
  // valid stays high with garbage while busy and the next request is presented
  // in the DONE cycle, so it is accepted as soon as ready returns.
  task automatic run_op(input logic [1:0] op, input logic [4:0] idx,
                        input logic [27:0] val, input logic [27:0] care,
                        input bit hold, input logic [1:0] n_op, input logic [4:0] n_idx,
                        input logic [27:0] n_val, input logic [27:0] n_care,
                        output int waited);
    logic [3:0]  exp_mask;
    logic [31:0] exp_w;
    waited = 0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_idx_i   = idx;
    bus.req_value_i = val;
    bus.req_care_i  = care;
    while (bus.req_ready_o !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout op=%0d ready=%b required 1", op, bus.req_ready_o);
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    model_apply(op, idx, val, care);
    @(negedge clk);
    bus.req_valid_i = hold;
    bus.req_op_i    = 2'($urandom);
    bus.req_idx_i   = 5'($urandom);
    bus.req_value_i = 28'($urandom);
    bus.req_care_i  = 28'($urandom);
    exp_mask = (op == 2'b10) ? 4'hF : (4'b0001 << idx[4:3]);
    if (op != 2'b11) begin
      for (int c = 0; c < 512; c++) begin
        exp_w = model_word(c);
        n_tests++;
        if ({bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
             bus.tcam_wdata_o, bus.busy_o, bus.done_o, bus.req_ready_o} !==
            {1'b0, 1'b0, exp_mask, 28'(c), exp_w, 1'b1, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL write_word op=%0d c=%0d got csb=%b web=%b mask=%h addr=%h data=%h busy=%b done=%b rdy=%b required mask=%h addr=%h data=%h",
                   op, c, bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
                   bus.tcam_wdata_o, bus.busy_o, bus.done_o, bus.req_ready_o,
                   exp_mask, 28'(c), exp_w);
        end
        cap[c] = bus.tcam_wdata_o;
        for (int b = 0; b < 4; b++)
          if (bus.tcam_wmask_o[b] === 1'b1) sram[c][8*b +: 8] = bus.tcam_wdata_o[8*b +: 8];
        @(negedge clk);
      end
    end
    n_tests++;
    if ({bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
         bus.tcam_wdata_o, bus.busy_o, bus.done_o, bus.req_ready_o} !==
        {1'b1, 1'b1, 4'h0, 28'h0, 32'h0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_cycle op=%0d got csb=%b web=%b mask=%h addr=%h busy=%b done=%b rdy=%b required csb=1 web=1 busy=1 done=1 rdy=0",
               op, bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
               bus.busy_o, bus.done_o, bus.req_ready_o);
    end
    if (hold) begin
      bus.req_op_i    = n_op;
      bus.req_idx_i   = n_idx;
      bus.req_value_i = n_val;
      bus.req_care_i  = n_care;
    end
    @(negedge clk);
    n_tests++;
    if ({bus.req_ready_o, bus.busy_o, bus.done_o, bus.tcam_csb_o} !== 4'b1001) begin
      n_fail++;
      $display("FAIL ready_return op=%0d got rdy=%b busy=%b done=%b csb=%b required rdy=1 busy=0 done=0 csb=1",
               op, bus.req_ready_o, bus.busy_o, bus.done_o, bus.tcam_csb_o);
    end
  endtask

  task automatic test_reset();
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'b11;
    bus.req_idx_i   = '0;
    bus.req_value_i = '0;
    bus.req_care_i  = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) sram[i] = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
         bus.tcam_wdata_o, bus.busy_o, bus.done_o, bus.req_ready_o} !==
        {1'b1, 1'b1, 4'h0, 28'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs got csb=%b web=%b mask=%h addr=%h data=%h busy=%b done=%b rdy=%b required idle values with rdy=0",
               bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
               bus.tcam_wdata_o, bus.busy_o, bus.done_o, bus.req_ready_o);
    end
    rst_n = 1'b1;
    m_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({bus.req_ready_o, bus.busy_o, bus.done_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b busy=%b done=%b required 1 0 0",
               bus.req_ready_o, bus.busy_o, bus.done_o);
    end
  endtask

  task automatic test_clear();
    int w;
    int nz = 0;
    run_op(2'b10, 5'd0, 28'h0, 28'h0, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    for (int c = 0; c < 512; c++) if (cap[c] != 32'h0) nz++;
    n_tests++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL clear_zero_words got %0d nonzero words required 0", nz);
    end
  endtask

  task automatic test_install_exact();
    int w;
    logic [511:0] hits, exp_hits;
    logic [31:0]  res;
    run_op(2'b00, 5'd0, 28'h0, 28'hFFFFFFF, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    exp_hits = '0;
    exp_hits[0] = 1'b1; exp_hits[128] = 1'b1; exp_hits[256] = 1'b1; exp_hits[384] = 1'b1;
    for (int c = 0; c < 512; c++) hits[c] = cap[c][0];
    n_tests++;
    if (hits !== exp_hits) begin
      n_fail++;
      $display("FAIL exact_bit0_positions got %0d set bits required bits 0,128,256,384 only", $countones(hits));
    end
    res = sram_search(28'h0);
    n_tests++;
    if (res !== 32'h1) begin
      n_fail++;
      $display("FAIL exact_search_key0 got %h required 00000001", res);
    end
  endtask

  task automatic test_dont_care();
    int w;
    int ones;
    run_op(2'b00, 5'd9, 28'($urandom), 28'h0, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    ones = 0;
    for (int c = 0; c < 512; c++) if (cap[c][9]) ones++;
    n_tests++;
    if (ones !== 512) begin
      n_fail++;
      $display("FAIL dontcare_bit9_all got %0d words with bit 9 required 512", ones);
    end
    run_op(2'b01, 5'd9, 28'($urandom), 28'($urandom), 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    ones = 0;
    for (int c = 0; c < 512; c++) if (cap[c][9]) ones++;
    n_tests++;
    if (ones !== 0) begin
      n_fail++;
      $display("FAIL delete_bit9_none got %0d words with bit 9 required 0", ones);
    end
  endtask

  task automatic test_same_byte();
    int w;
    logic [511:0] hits, exp_hits;
    run_op(2'b00, 5'd8, 28'h0000001, 28'hFFFFFFF, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    run_op(2'b00, 5'd9, 28'($urandom), 28'h0, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    exp_hits = '0;
    exp_hits[0] = 1'b1; exp_hits[128] = 1'b1; exp_hits[256] = 1'b1; exp_hits[385] = 1'b1;
    for (int c = 0; c < 512; c++) hits[c] = cap[c][8];
    n_tests++;
    if (hits !== exp_hits) begin
      n_fail++;
      $display("FAIL same_byte_bit8 got %0d set bits (bit385=%b) required bits 0,128,256,385",
               $countones(hits), hits[385]);
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic [27:0] v1 = 28'($urandom), c1 = 28'($urandom);
    logic [27:0] v2 = 28'($urandom), c2 = 28'($urandom) & 28'($urandom);
    logic [31:0] res, exp;
    run_op(2'b00, 5'd20, v1, c1, 1'b1, 2'b00, 5'd21, v2, c2, w);
    run_op(2'b00, 5'd21, v2, c2, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    n_tests++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL backpressure_accept got %0d extra wait cycles required 0", w);
    end
    res = sram_search(v2);
    exp = model_match(v2);
    n_tests++;
    if (res !== exp) begin
      n_fail++;
      $display("FAIL backpressure_search got %h required %h", res, exp);
    end
  endtask

  task automatic test_reset_mid_write();
    int w = 0;
    int dones = 0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'b00;
    bus.req_idx_i   = 5'd3;
    bus.req_value_i = 28'($urandom);
    bus.req_care_i  = 28'($urandom);
    while (bus.req_ready_o !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_accept_timeout ready=%b required 1", bus.req_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (200) @(negedge clk);
    n_tests++;
    if ({bus.tcam_csb_o, bus.tcam_addr_o} !== {1'b0, 28'd200}) begin
      n_fail++;
      $display("FAIL midreset_at_word200 got csb=%b addr=%0d required csb=0 addr=200",
               bus.tcam_csb_o, bus.tcam_addr_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
         bus.tcam_wdata_o, bus.busy_o, bus.done_o, bus.req_ready_o} !==
        {1'b1, 1'b1, 4'h0, 28'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_abort got csb=%b web=%b mask=%h addr=%h busy=%b done=%b rdy=%b required idle with busy=0 done=0",
               bus.tcam_csb_o, bus.tcam_web_o, bus.tcam_wmask_o, bus.tcam_addr_o,
               bus.busy_o, bus.done_o, bus.req_ready_o);
    end
    rst_n = 1'b1;
    m_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({bus.req_ready_o, bus.done_o, bus.busy_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL midreset_release got rdy=%b done=%b busy=%b required 1 0 0",
               bus.req_ready_o, bus.done_o, bus.busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.done_o !== 1'b0) dones++;
      @(negedge clk);
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done got %0d done cycles required 0", dones);
    end
    run_op(2'b11, 5'd0, 28'h0, 28'h0, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
    run_op(2'b10, 5'd0, 28'h0, 28'h0, 1'b0, 2'b0, 5'd0, 28'h0, 28'h0, w);
  endtask

  task automatic test_random();
    int w;
    int sel;
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [27:0] key;
    logic [31:0] res, exp;
    for (int n = 0; n < 14; n++) begin
      sel = $urandom_range(0, 9);
      op  = (sel <= 5) ? 2'b00 : (sel <= 7) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
      idx = 5'($urandom);
      run_op(op, idx, 28'($urandom), 28'($urandom) & 28'($urandom), 1'b0,
             2'b0, 5'd0, 28'h0, 28'h0, w);
      for (int k = 0; k < 4; k++) begin
        idx = 5'($urandom);
        key = (k < 2) ? ((m_val[idx] & m_care[idx]) | (28'($urandom) & ~m_care[idx]))
                      : 28'($urandom);
        res = sram_search(key);
        exp = model_match(key);
        n_tests++;
        if (res !== exp) begin
          n_fail++;
          $display("FAIL random_search op=%0d key=%h got %h required %h", op, key, res, exp);
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_val[r]  = '0;
      m_care[r] = '0;
    end
    test_reset();
    test_clear();
    test_install_exact();
    test_dont_care();
    test_same_byte();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
